screen_sequencer: RTL and testbench
===================================

// Module: screen_sequencer
// PURPOSE
//  Selects which demo screen generator (pattern, triangles, frame, moving object) drives the VGA DAC mux.
//  Replaces the unsynchronised KEY-edge counter in the top level.
//  Debounces the next/prev keys and optionally auto-cycles screens.
//  Applies a change only at end of the active frame, then mutes RGB for MUTE_FRAMES frames so the switch never tears.
//  Sits between KEY/SW and the r/g/b screen mux, clocked by VGA_CLK.
// PARAMETERS
//  N_SCREENS    4         number of selectable screens, >=2; sel wraps modulo N_SCREENS
//  SEL_W        2         width of sel, must satisfy 2**SEL_W >= N_SCREENS
//  DEBOUNCE     1_080_000 clk cycles a key level must be stable to be accepted (10 ms @108 MHz)
//  AUTO_FRAMES  300       frames between automatic advances when auto_en=1
//  MUTE_FRAMES  1         whole frames mute stays high after a switch, >=1
// PORTS
//  clk          in   1      pixel clock (VGA_CLK)
//  rst_n        in   1      asynchronous active-low reset
//  key_next_n   in   1      raw pushbutton, active low, asynchronous to clk
//  key_prev_n   in   1      raw pushbutton, active low, asynchronous to clk
//  auto_en      in   1      slide switch, asynchronous; 1 = auto-cycle forward
//  v_enable     in   1      vertical display-time flag from timing block
//  sel          out  SEL_W  current screen index to RGB mux
//  mute         out  1      1 = top level forces VGA_R/G/B to 0
//  switch_pulse out  1      one-cycle strobe on the cycle sel changes
//  busy         out  1      1 while a change is pending or muting
// BEHAVIOUR
//  Reset: sel=0, mute=0, switch_pulse=0, busy=0, FSM=SHOW, counters=0, pending=0, sync/debounced key state=released(1).
//  Input conditioning:
//  - key_next_n, key_prev_n and auto_en each pass a 2-FF synchroniser.
//  - Debounce per key: counter resets on any change of the synced level versus the accepted level.
//  - The accepted level updates after DEBOUNCE consecutive equal cycles.
//  - A press event is the accepted level going 1->0, as a one-cycle pulse.
//  Frame end (fe): v_enable 1->0 edge detected on registered v_enable; one-cycle pulse.
//  Auto tick:
//  - Frame counter increments on fe while auto_en_sync=1. It is held at 0 while auto_en_sync=0.
//  - When it reaches AUTO_FRAMES-1 on an fe, it wraps to 0 and raises the auto request.
//  Request resolution, evaluated every cycle:
//  - next and prev pulses in the same cycle cancel; no request.
//  - next or auto gives dir=+1. prev gives dir=-1.
//  - A user key in the same cycle as auto: the key's direction wins; still one step only.
//  - One pending slot holds {pending, dir}. A new request while pending=1 overwrites dir only (coalesce; no queue).
//  FSM:
//  - SHOW: on a request, latch pending/dir and go to PEND. If pending is already 1 on entry, go to PEND immediately.
//  - PEND: busy=1. On fe:
//    - sel <= sel+dir mod N_SCREENS (N_SCREENS-1 +1 -> 0; 0 -1 -> N_SCREENS-1).
//    - switch_pulse=1 for that cycle, mute<=1, pending<=0, mute counter<=0, go to MUTE.
//  - MUTE: busy=1, mute=1. The mute counter increments on each fe.
//    - When it reaches MUTE_FRAMES on an fe: mute<=0 and go to SHOW.
//    - Requests arriving in MUTE are latched into pending and serviced from SHOW.
//  - A request and fe in the same cycle while in SHOW: the request goes to PEND; the switch happens at the next fe, not this one.
//  - mute is registered. It rises the cycle after fe at the earliest, i.e. inside vertical blanking.
//  - sel changes only on an fe cycle, so it is constant throughout any active frame.
//  Reset mid-operation: everything returns to reset values at once and asynchronously; pending requests are discarded.
//  Arithmetic: sel add/sub is done in SEL_W+1 bits, then wrapped with an explicit compare to N_SCREENS. No reliance on natural overflow unless 2**SEL_W==N_SCREENS.
//  Counter widths come from $clog2 of DEBOUNCE, AUTO_FRAMES+1 and MUTE_FRAMES+1.
// STRUCTURE
//  Shared package/header vga_pkg: FSM state encodings S_SHOW/S_PEND/S_MUTE (2 bits), DEBOUNCE default for 108 MHz.
//  The timing constants H/V already live there.
//  Sub-module key_debounce (synchroniser, debounce counter, press-pulse output) instantiated twice.
//  auto_en uses a bare 2-FF synchroniser, no debounce.
//  Remaining logic (fe detect, auto counter, request arbitration, FSM, sel arithmetic) is flat in screen_sequencer.
// TESTING  (bench uses DEBOUNCE=8, AUTO_FRAMES=3, MUTE_FRAMES=1, synthetic v_enable with 100-cycle frames)
//  1 Reset: rst_n low mid-frame -> sel=0, mute=0, busy=0 immediately. After release no change without a key press.
//  2 key_next_n low 20 cycles -> exactly one switch.
//    - At the next fe: sel 0->1 with a 1-cycle switch_pulse, mute high for 1 frame, then busy=0.
//  3 Bounce: key_next_n toggled every 3 cycles for 40 cycles, then held low -> exactly one sel increment.
//  4 Wrap: sel=3, press next -> sel=0. From sel=0, press prev -> sel=3.
//    - next+prev accepted in the same cycle -> sel unchanged, switch_pulse never asserted.
//  5 auto_en=1 for 12 frames, no keys -> sel steps every 3rd fe.
//    - Each step is followed by a mute frame. auto_en=0 -> stepping stops and the counter is cleared.
//  6 Coalesce: press next, then press prev before the fe -> at the fe sel decrements once.
//    - A press during MUTE -> serviced on the fe after mute drops; sel never changes on a non-fe cycle.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the VGA demo top level.
//   - 1280x1024 @ 60 Hz timing constants (108 MHz pixel clock)
//   - screen sequencer FSM state encoding
//   - default key debounce length for the 108 MHz pixel clock
//   - cnt_w(): counter width helper that never returns zero
package vga_pkg;

  localparam int H_ACTIVE = 1280;
  localparam int H_FP     = 48;
  localparam int H_SYNC   = 112;
  localparam int H_BP     = 248;
  localparam int V_ACTIVE = 1024;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 3;
  localparam int V_BP     = 38;

  // 10 ms at 108 MHz
  localparam int DEBOUNCE_108M = 1_080_000;

  typedef enum logic [1:0] {
    S_SHOW = 2'd0,
    S_PEND = 2'd1,
    S_MUTE = 2'd2
  } seq_state_e;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/screen_sequencer_key_debounce.sv
// key_debounce: conditions one raw active-low pushbutton.
//   clk     in  pixel clock
//   rst_n   in  asynchronous active-low reset
//   key_n   in  raw key level, asynchronous to clk
//   press   out one-cycle pulse when the accepted level goes 1->0
// The synced level must differ from the accepted level for DEBOUNCE
// consecutive cycles before it is accepted; any return to the accepted
// level restarts the count.
module key_debounce
  import vga_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_108M
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = cnt_w(DEBOUNCE);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          meta_q, sync_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= key_n;
      sync_q  <= meta_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q;
        press_d = ~sync_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/screen_sequencer.sv
// screen_sequencer: picks which demo screen drives the VGA DAC mux.
//   clk          in  pixel clock (VGA_CLK)
//   rst_n        in  asynchronous active-low reset
//   key_next_n   in  raw pushbutton, active low, steps forward
//   key_prev_n   in  raw pushbutton, active low, steps backward
//   auto_en      in  slide switch, 1 = advance every AUTO_FRAMES frames
//   v_enable     in  vertical display-time flag
//   sel          out current screen index
//   mute         out 1 = force RGB to 0
//   switch_pulse out one-cycle strobe on the cycle sel changes
//   busy         out change pending or muting
//
// state  | meaning
// S_SHOW | idle, screen displayed, waiting for a request
// S_PEND | request latched, switch at the next frame end
// S_MUTE | switched, RGB muted until MUTE_FRAMES frame ends pass
module screen_sequencer
  import vga_pkg::*;
#(
  parameter int N_SCREENS   = 4,
  parameter int SEL_W       = 2,
  parameter int DEBOUNCE    = DEBOUNCE_108M,
  parameter int AUTO_FRAMES = 300,
  parameter int MUTE_FRAMES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_next_n,
  input  logic             key_prev_n,
  input  logic             auto_en,
  input  logic             v_enable,
  output logic [SEL_W-1:0] sel,
  output logic             mute,
  output logic             switch_pulse,
  output logic             busy
);

  localparam int AW = cnt_w(AUTO_FRAMES + 1);
  localparam int MW = cnt_w(MUTE_FRAMES + 1);
  localparam logic [AW-1:0]  AUTO_LAST = AW'(AUTO_FRAMES - 1);
  localparam logic [AW-1:0]  A_ONE     = AW'(1);
  localparam logic [MW-1:0]  MUTE_END  = MW'(MUTE_FRAMES);
  localparam logic [MW-1:0]  M_ONE     = MW'(1);
  localparam logic [SEL_W:0] N_W       = (SEL_W + 1)'(N_SCREENS);
  localparam logic [SEL_W:0] N_M1      = (SEL_W + 1)'(N_SCREENS - 1);
  localparam logic [SEL_W:0] S_ONE     = (SEL_W + 1)'(1);

  logic press_next, press_prev;

  key_debounce #(.DEBOUNCE(DEBOUNCE)) u_key_next (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_next_n),
    .press (press_next)
  );

  key_debounce #(.DEBOUNCE(DEBOUNCE)) u_key_prev (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_prev_n),
    .press (press_prev)
  );

  logic             auto_meta_q, auto_sync_q, ven_q;
  seq_state_e       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             dir_q, dir_d;          // 1 = step backwards
  logic             pending_q, pending_d;
  logic             mute_q, mute_d;
  logic [AW-1:0]    acnt_q, acnt_d;
  logic [MW-1:0]    mcnt_q, mcnt_d;
  logic             fe, auto_req, req, req_minus;

  // Wrap in SEL_W+1 bits so non-power-of-two N_SCREENS is handled.
  function automatic logic [SEL_W-1:0] step_sel(input logic [SEL_W-1:0] s,
                                                input logic minus);
    logic [SEL_W:0] t;
    t = minus ? ({1'b0, s} + N_M1) : ({1'b0, s} + S_ONE);
    if (t >= N_W) t = t - N_W;
    return t[SEL_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_meta_q <= 1'b0;
      auto_sync_q <= 1'b0;
      ven_q       <= 1'b0;
      state_q     <= S_SHOW;
      sel_q       <= '0;
      dir_q       <= 1'b0;
      pending_q   <= 1'b0;
      mute_q      <= 1'b0;
      acnt_q      <= '0;
      mcnt_q      <= '0;
    end else begin
      auto_meta_q <= auto_en;
      auto_sync_q <= auto_meta_q;
      ven_q       <= v_enable;
      state_q     <= state_d;
      sel_q       <= sel_d;
      dir_q       <= dir_d;
      pending_q   <= pending_d;
      mute_q      <= mute_d;
      acnt_q      <= acnt_d;
      mcnt_q      <= mcnt_d;
    end
  end

  assign fe = ven_q & ~v_enable;

  always_comb begin
    acnt_d   = acnt_q;
    auto_req = 1'b0;
    if (!auto_sync_q) begin
      acnt_d = '0;
    end else if (fe) begin
      if (acnt_q == AUTO_LAST) begin
        acnt_d   = '0;
        auto_req = 1'b1;
      end else begin
        acnt_d = acnt_q + A_ONE;
      end
    end
  end

  // Simultaneous next+prev cancel outright; a key beats auto.
  always_comb begin
    req       = 1'b0;
    req_minus = 1'b0;
    if (press_next && press_prev) begin
      req = 1'b0;
    end else if (press_prev) begin
      req       = 1'b1;
      req_minus = 1'b1;
    end else if (press_next || auto_req) begin
      req = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    dir_d        = dir_q;
    pending_d    = pending_q;
    mute_d       = mute_q;
    mcnt_d       = mcnt_q;
    switch_pulse = 1'b0;
    case (state_q)
      S_SHOW: begin
        // A request on a frame-end cycle waits for the following frame end.
        if (req) begin
          pending_d = 1'b1;
          dir_d     = req_minus;
          state_d   = S_PEND;
        end else if (pending_q) begin
          state_d = S_PEND;
        end
      end
      S_PEND: begin
        if (req) dir_d = req_minus;
        if (fe) begin
          sel_d        = step_sel(sel_q, req ? req_minus : dir_q);
          switch_pulse = 1'b1;
          mute_d       = 1'b1;
          pending_d    = 1'b0;
          mcnt_d       = '0;
          state_d      = S_MUTE;
        end
      end
      S_MUTE: begin
        if (req) begin
          pending_d = 1'b1;
          dir_d     = req_minus;
        end
        if (fe) begin
          mcnt_d = mcnt_q + M_ONE;
          if (mcnt_d == MUTE_END) begin
            mute_d  = 1'b0;
            state_d = S_SHOW;
          end
        end
      end
      default: state_d = S_SHOW;
    endcase
  end

  assign sel  = sel_q;
  assign mute = mute_q;
  assign busy = (state_q != S_SHOW) || pending_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// tb_screen_sequencer: directed and randomized frame-level checks of
// screen_sequencer with 100-cycle synthetic frames (80 active, 20 blank).
module tb_screen_sequencer;

  localparam int N      = 4;
  localparam int AUTO_F = 3;
  localparam int MUTE_F = 1;
  localparam int FRAME  = 100;
  localparam int ACTIVE = 80;

  localparam int A_NONE = 0, A_NEXT = 1, A_PREV = 2, A_BOTH = 3, A_COAL = 4, A_BOUNCE = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_next_n = 1'b1;
  logic       key_prev_n = 1'b1;
  logic       auto_en = 1'b0;
  logic       v_enable = 1'b0;
  logic [1:0] sel;
  logic       mute, switch_pulse, busy;

  int checks = 0;
  int failures = 0;
  int fcnt = FRAME - 1;

  screen_sequencer #(
    .N_SCREENS(N), .SEL_W(2), .DEBOUNCE(8), .AUTO_FRAMES(AUTO_F), .MUTE_FRAMES(MUTE_F)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_next_n(key_next_n), .key_prev_n(key_prev_n),
    .auto_en(auto_en), .v_enable(v_enable), .sel(sel), .mute(mute),
    .switch_pulse(switch_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  // Frame phase advances on the falling edge; phase ACTIVE is the frame-end cycle.
  initial forever begin
    @(negedge clk);
    fcnt = (fcnt == FRAME - 1) ? 0 : fcnt + 1;
    v_enable = (fcnt < ACTIVE);
  end

  int         pulse_cnt = 0, pulse_off_fe = 0, sel_off_fe = 0, mute_off_fe = 0;
  logic [1:0] last_sel = 2'd0;
  logic       last_mute = 1'b0;

  initial forever begin
    @(negedge clk);
    #3;
    if (rst_n && switch_pulse === 1'b1) begin
      pulse_cnt++;
      if (fcnt != ACTIVE) pulse_off_fe++;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (sel !== last_sel && fcnt != ACTIVE) sel_off_fe++;
      if (mute !== last_mute && fcnt != ACTIVE) mute_off_fe++;
    end
    last_sel = sel;
    last_mute = mute;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Frame-level reference model.
  int m_sel = 0, m_pend = 0, m_dir = 1, m_mute = 0, m_mcnt = 0;
  int m_acnt = 0, m_auto = 0, m_steps = 0;

  task automatic model_req(input int d);
    m_pend = 1;
    m_dir  = d;
  endtask

  task automatic model_fe();
    int areq;
    areq = 0;
    if (m_auto != 0) begin
      m_acnt++;
      if (m_acnt == AUTO_F) begin
        m_acnt = 0;
        areq = 1;
      end
    end else begin
      m_acnt = 0;
    end
    if (m_mute != 0) begin
      m_mcnt++;
      if (m_mcnt == MUTE_F) m_mute = 0;
    end else if (m_pend != 0) begin
      m_sel = (m_sel + m_dir + N) % N;
      m_pend = 0;
      m_mute = 1;
      m_mcnt = 0;
      m_steps++;
    end
    if (areq != 0) model_req(1);
  endtask

  task automatic model_reset();
    m_sel = 0; m_pend = 0; m_dir = 1; m_mute = 0; m_mcnt = 0; m_acnt = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic to_phase(input int p);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (fcnt != p && n < 3 * FRAME);
    checks++;
    assert (fcnt == p) else begin
      failures++;
      $error("FAIL phase_wait observed=%0d expected=%0d", fcnt, p);
    end
  endtask

  task automatic set_auto(input int v);
    auto_en = (v != 0);
    m_auto = v;
    if (v == 0) m_acnt = 0;
  endtask

  task automatic do_frame(input int act, input int off, input string tag);
    to_phase(off);
    case (act)
      A_NEXT: begin
        key_next_n = 1'b0; repeat (20) cycle(); key_next_n = 1'b1;
        model_req(1);
      end
      A_PREV: begin
        key_prev_n = 1'b0; repeat (20) cycle(); key_prev_n = 1'b1;
        model_req(-1);
      end
      A_BOTH: begin
        key_next_n = 1'b0; key_prev_n = 1'b0; repeat (20) cycle();
        key_next_n = 1'b1; key_prev_n = 1'b1;
      end
      A_COAL: begin
        key_next_n = 1'b0; repeat (15) cycle(); key_next_n = 1'b1;
        to_phase(off + 35);
        key_prev_n = 1'b0; repeat (15) cycle(); key_prev_n = 1'b1;
        model_req(1);
        model_req(-1);
      end
      A_BOUNCE: begin
        for (int i = 0; i < 40; i++) begin
          key_next_n = ((i / 3) % 2) != 0;
          cycle();
        end
        key_next_n = 1'b0; repeat (15) cycle(); key_next_n = 1'b1;
        model_req(1);
      end
      default: ;
    endcase
    to_phase(ACTIVE + 5);
    model_fe();
    check({tag, "_sel"}, sel, m_sel);
    check({tag, "_mute"}, mute, m_mute);
    check({tag, "_busy"}, busy, (m_mute != 0 || m_pend != 0) ? 1 : 0);
  endtask

  initial begin
    int act, off;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sel", sel, 0);
    check("rst_mute", mute, 0);
    check("rst_busy", busy, 0);
    check("rst_pulse", switch_pulse, 0);
    rst_n = 1'b1;

    do_frame(A_NONE, 5, "idle");
    do_frame(A_NEXT, 5, "next");
    check("next_pulses", pulse_cnt, 1);
    do_frame(A_NONE, 5, "next_unmute");
    do_frame(A_BOUNCE, 2, "bounce");
    do_frame(A_NONE, 5, "bounce_unmute");
    check("bounce_pulses", pulse_cnt, m_steps);
    do_frame(A_NEXT, 5, "to3");
    do_frame(A_NONE, 5, "to3_unmute");
    do_frame(A_NEXT, 5, "wrap_up");
    do_frame(A_NONE, 5, "wrap_up_unmute");
    do_frame(A_PREV, 5, "wrap_down");
    do_frame(A_NONE, 5, "wrap_down_unmute");
    do_frame(A_BOTH, 5, "cancel");
    do_frame(A_NONE, 5, "cancel_idle");
    check("cancel_pulses", pulse_cnt, m_steps);
    do_frame(A_COAL, 5, "coal");
    do_frame(A_NEXT, 5, "mute_press");
    do_frame(A_NONE, 5, "mute_serviced");
    do_frame(A_NONE, 5, "mute_serviced_unmute");

    // Reset with a pending request in flight.
    to_phase(5);
    key_next_n = 1'b0; repeat (20) cycle(); key_next_n = 1'b1;
    to_phase(45);
    check("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_sel", sel, 0);
    check("midrst_mute", mute, 0);
    check("midrst_busy", busy, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #4;
    rst_n = 1'b1;
    to_phase(ACTIVE + 5);
    model_fe();
    check("post_rst_sel", sel, m_sel);
    check("post_rst_busy", busy, 0);
    do_frame(A_NONE, 5, "post_rst_idle");

    // Auto-cycling, then disable to clear the frame counter, then re-enable.
    to_phase(5);
    set_auto(1);
    for (int i = 0; i < 13; i++) do_frame(A_NONE, 10, "auto");
    check("auto_pulses", pulse_cnt, m_steps);
    to_phase(5);
    set_auto(0);
    for (int i = 0; i < 3; i++) do_frame(A_NONE, 10, "auto_off");
    to_phase(5);
    set_auto(1);
    for (int i = 0; i < 5; i++) do_frame(A_NONE, 10, "auto_re");
    to_phase(5);
    set_auto(0);
    for (int i = 0; i < 3; i++) do_frame(A_NONE, 10, "auto_drain");

    for (int i = 0; i < 30; i++) begin
      act = int'($urandom_range(0, 5));
      off = (act == A_BOUNCE) ? int'($urandom_range(2, 10)) : int'($urandom_range(2, 20));
      do_frame(act, off, "rand");
    end
    do_frame(A_NONE, 5, "final_a");
    do_frame(A_NONE, 5, "final_b");

    check("total_pulses", pulse_cnt, m_steps);
    check("pulse_off_fe", pulse_off_fe, 0);
    check("sel_off_fe", sel_off_fe, 0);
    check("mute_off_fe", mute_off_fe, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
